// File: rtl/dom_ssaes_pkg.sv
// ---------------------------------------------------------------------------
// dom_ssaes_pkg
// Shared constants, FSM encoding and GF(2^4) helpers for the DOM-protected
// 16-bit small-scale AES datapath.
//   - NIB_W / NUM_NIB / STATE_W / Z_W : datapath geometry
//   - state_e                         : masked SubNibbles sequencer states
//   - LFSR_POLY                       : Galois mask for x^32+x^22+x^2+x+1
//   - SBOX_TABLE                      : golden unmasked 4-bit S-box
//   - gf16_mul / gf16_sq / sbox_lin   : GF(2^4) arithmetic, modulus x^4+x+1
// ---------------------------------------------------------------------------
package dom_ssaes_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int STATE_W = 16;
  localparam int Z_W     = 12;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Right-shifting Galois form: bits 31, 21, 1, 0 stand for x^32, x^22, x^2, x^1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // S(x) = L(x^-1) ^ SBOX_C, with 0^-1 taken as 0.
  localparam logic [3:0] SBOX_TABLE [16] = '{
    4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
    4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8
  };
  localparam logic [3:0] SBOX_C = 4'h6;

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      // Multiply by x and reduce: x^4 = x + 1.
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  // Squaring is linear in GF(2^4), so it can be applied to each share alone.
  function automatic logic [3:0] gf16_sq(input logic [3:0] a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  // Linear part of the S-box affine map; columns are L(1)=D, L(2)=B, L(4)=7, L(8)=E.
  function automatic logic [3:0] sbox_lin(input logic [3:0] y);
    return ({4{y[0]}} & 4'hD) ^ ({4{y[1]}} & 4'hB) ^
           ({4{y[2]}} & 4'h7) ^ ({4{y[3]}} & 4'hE);
  endfunction

endpackage

// File: rtl/dom_rand_lfsr.sv
// ---------------------------------------------------------------------------
// dom_rand_lfsr
// 32-bit Galois LFSR supplying the fresh randomness for the masked S-box.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset (state -> SEED_RST)
//   load_i  : load seed_i (a zero seed is replaced by 1, the lock-up state)
//   seed_i  : 32-bit seed
//   step_i  : advance one step
//   z_o     : low 12 bits of the current state (Z0..Z5, two bits each)
// ---------------------------------------------------------------------------
module dom_rand_lfsr
  import dom_ssaes_pkg::*;
#(
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [31:0]      seed_i,
  input  logic             step_i,
  output logic [Z_W-1:0]   z_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    // NOTE: the hold value is assigned first so every path defines lfsr_d and no latch is inferred.
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? 32'h0000_0001 : seed_i;
    end else if (step_i) begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) lfsr_q <= SEED_RST;
    else     lfsr_q <= lfsr_d;
  end

  assign z_o = lfsr_q[Z_W-1:0];

endmodule

// File: rtl/dom_sbox.sv
// ---------------------------------------------------------------------------
// dom_sbox
// First-order DOM-indep masked 4-bit S-box, three register stages.
// Computes x^14 (= x^-1) as x^12 * x^2 with x^3 = x * x^2, then the affine map.
//   clk          : clock, rising edge (no reset: pure datapath)
//   Z0..Z5       : 2-bit fresh random words, consumed in the input cycle
//   A, B         : input shares, A ^ B = x
//   A_out, B_out : output shares, A_out ^ B_out = S(x), valid 3 edges later
// ---------------------------------------------------------------------------
module dom_sbox
  import dom_ssaes_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] Z0,
  input  logic [1:0] Z1,
  input  logic [1:0] Z2,
  input  logic [1:0] Z3,
  input  logic [1:0] Z4,
  input  logic [1:0] Z5,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] A_out,
  output logic [3:0] B_out
);

  logic [3:0] sq_a, sq_b;
  logic [3:0] s0_aa_q, s0_ab_q, s0_bb_q, s0_ba_q;
  logic [3:0] s0_sqa_q, s0_sqb_q, s0_z_q;
  logic [3:0] x3_a, x3_b, x12_a, x12_b;
  logic [3:0] s1_aa_q, s1_ab_q, s1_bb_q, s1_ba_q;

  assign sq_a = gf16_sq(A);
  assign sq_b = gf16_sq(B);

  // NOTE: no reset on these pipeline flops; the caller tracks validity, so stale data is never consumed.
  // Stage 0: x^3 = x * x^2. Cross-domain products are masked by {Z1,Z0} before the register.
  // The x^2 shares are re-masked by {Z5,Z4}; {Z3,Z2} is carried to stage 1.
  always_ff @(posedge clk) begin
    s0_aa_q  <= gf16_mul(A, sq_a);
    s0_ab_q  <= gf16_mul(A, sq_b) ^ {Z1, Z0};
    s0_bb_q  <= gf16_mul(B, sq_b);
    s0_ba_q  <= gf16_mul(B, sq_a) ^ {Z1, Z0};
    s0_sqa_q <= sq_a ^ {Z5, Z4};
    s0_sqb_q <= sq_b ^ {Z5, Z4};
    s0_z_q   <= {Z3, Z2};
  end

  // Share compression happens only after the register, never across domains.
  assign x3_a  = s0_aa_q ^ s0_ab_q;
  assign x3_b  = s0_bb_q ^ s0_ba_q;
  assign x12_a = gf16_sq(gf16_sq(x3_a));
  assign x12_b = gf16_sq(gf16_sq(x3_b));

  // Stage 1: x^14 = x^12 * x^2.
  always_ff @(posedge clk) begin
    s1_aa_q <= gf16_mul(x12_a, s0_sqa_q);
    s1_ab_q <= gf16_mul(x12_a, s0_sqb_q) ^ s0_z_q;
    s1_bb_q <= gf16_mul(x12_b, s0_sqb_q);
    s1_ba_q <= gf16_mul(x12_b, s0_sqa_q) ^ s0_z_q;
  end

  // Stage 2: affine map; the constant goes onto share A only.
  always_ff @(posedge clk) begin
    A_out <= sbox_lin(s1_aa_q ^ s1_ab_q) ^ SBOX_C;
    B_out <= sbox_lin(s1_bb_q ^ s1_ba_q);
  end

endmodule

// File: rtl/masked_sub_nibbles.sv
// ---------------------------------------------------------------------------
// masked_sub_nibbles
// Masked SubNibbles layer: streams four nibble share pairs through one
// pipelined DOM S-box and reassembles the 2-share result.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   start      : request, sampled only in IDLE; in_a/in_b latched on that edge
//   in_a, in_b : input state shares, nibble k = [4k+3:4k]
//   seed_load  : load seed into the LFSR, honoured only in IDLE
//   seed       : LFSR seed (0 becomes 1)
//   busy       : high from accepted start until the done edge
//   done       : one-cycle pulse when out_a/out_b are complete
//   out_a/b    : result shares, held until overwritten by the next run
// ---------------------------------------------------------------------------
module masked_sub_nibbles
  import dom_ssaes_pkg::*;
#(
  parameter int          SBOX_LAT = 3,
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] in_a,
  input  logic [STATE_W-1:0] in_b,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] out_a,
  output logic [STATE_W-1:0] out_b
);

  state_e state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STATE_W-1:0] a_q, a_d, b_q, b_d;
  logic [STATE_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic               done_q, done_d;

  // In-flight tracking: one valid bit and nibble index per S-box stage.
  logic [SBOX_LAT-1:0]            vld_q, vld_d;
  logic [SBOX_LAT-1:0][IDX_W-1:0] vidx_q, vidx_d;
  logic                           cap_vld;
  logic [IDX_W-1:0]               cap_idx;

  logic             feed, lfsr_load;
  logic [Z_W-1:0]   lfsr_z, sbox_z;
  logic [NIB_W-1:0] sbox_a, sbox_b, sbox_a_out, sbox_b_out;

  // ---------------- sequencer ----------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    feed      = 1'b0;
    lfsr_load = 1'b0;
    case (state_q)
      IDLE: begin
        lfsr_load = seed_load;
        if (start) begin
          state_d = FEED;
          idx_d   = '0;
          a_d     = in_a;
          b_d     = in_b;
        end
      end
      FEED: begin
        feed  = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == IDX_W'(NUM_NIB - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (done_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- capture pipeline ----------------
  assign cap_vld = vld_q[SBOX_LAT-1];
  assign cap_idx = vidx_q[SBOX_LAT-1];

  always_comb begin
    vld_d     = '0;
    vidx_d    = '0;
    vld_d[0]  = feed;
    vidx_d[0] = idx_q;
    for (int i = 1; i < SBOX_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      vidx_d[i] = vidx_q[i-1];
    end
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (cap_vld) begin
      out_a_d[NIB_W*cap_idx +: NIB_W] = sbox_a_out;
      out_b_d[NIB_W*cap_idx +: NIB_W] = sbox_b_out;
    end
    done_d = cap_vld && (cap_idx == IDX_W'(NUM_NIB - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= '0;
      vidx_q  <= '0;
      out_a_q <= '0;
      out_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      vidx_q  <= vidx_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      done_q  <= done_d;
    end
  end

  // ---------------- randomness and S-box ----------------
  dom_rand_lfsr #(
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk    (clk),
    .rst    (reset),
    .load_i (lfsr_load),
    .seed_i (seed),
    .step_i (feed),
    .z_o    (lfsr_z)
  );

  // Outside FEED all S-box inputs sit at 0 so no stale share pair can
  // recombine in the S-box logic while idle.
  assign sbox_a = feed ? a_q[NIB_W*idx_q +: NIB_W] : '0;
  assign sbox_b = feed ? b_q[NIB_W*idx_q +: NIB_W] : '0;
  assign sbox_z = feed ? lfsr_z : '0;

  dom_sbox u_sbox (
    .clk   (clk),
    .Z0    (sbox_z[1:0]),
    .Z1    (sbox_z[3:2]),
    .Z2    (sbox_z[5:4]),
    .Z3    (sbox_z[7:6]),
    .Z4    (sbox_z[9:8]),
    .Z5    (sbox_z[11:10]),
    .A     (sbox_a),
    .B     (sbox_b),
    .A_out (sbox_a_out),
    .B_out (sbox_b_out)
  );

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign out_a = out_a_q;
  assign out_b = out_b_q;

endmodule
